// File: rtl/jtcps1_pkg.sv
// Shared constants and types for the CPS1 object line buffer.
package jtcps1_pkg;

   localparam int OBJ_AW = 9;
   localparam int OBJ_DW = 9;
   localparam logic [8:0] TRANSP_PXL = 9'h1FF;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } lb_state_t;

   // Colour nibble 4'hF marks a transparent object pixel.
   function automatic logic is_transp(input logic [OBJ_DW-1:0] pxl);
      return pxl[3:0] == 4'hF;
   endfunction

endpackage

// File: rtl/jtcps1_obj_linebuf_if.sv
// Drawer-side bus of the object line buffer: pixel writes in, line status out.
interface jtcps1_obj_linebuf_if #(parameter int AW = 9, parameter int DW = 9);
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] buf_data;
   logic          buf_wr;
   logic          line;
   logic          line_start;
   logic          busy;

   modport master (output buf_addr, buf_data, buf_wr, input line, line_start, busy);
   modport slave  (input buf_addr, buf_data, buf_wr, output line, line_start, busy);
endinterface

// File: rtl/jtcps1_linebuf_half.sv
// One half of the line buffer: simple dual-port RAM, one write port, registered read port.
module jtcps1_linebuf_half #(
   parameter int AW = 9,
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/jtcps1_obj_linebuf.sv
// Double-buffered object line buffer between the line drawer and the colour mixer.
// Build option JTCPS1_OBJ_FIRSTWIN_EN: first opaque write to a location wins (2-clk writes).
module jtcps1_obj_linebuf
   import jtcps1_pkg::*;
#(
   parameter int AW = OBJ_AW,
   parameter int DW = OBJ_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pxl_cen,
   input  logic                 HB,
   input  logic [AW-1:0]        hdump,
   jtcps1_obj_linebuf_if.slave  drw,
   output logic [DW-1:0]        obj_pxl
);
   lb_state_t     state, state_nx;
   logic          run;
   logic [AW:0]   cnt;
   logic          line_r, line_start_r, hb_r, hb_edge;
   logic          sel_r, blank_r, erase_pend_r;
   logic [AW-1:0] erase_addr_r;
   logic [DW-1:0] rdata [2];

   logic          drw_we, drw_half, drw_rd;
   logic [AW-1:0] drw_addr;
   logic [DW-1:0] drw_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_CLEAR;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_CLEAR: if (cnt == {(AW+1){1'b1}}) state_nx = ST_RUN;
                   else                       state_nx = ST_CLEAR;
         ST_RUN:   state_nx = ST_RUN;
         default:  state_nx = ST_CLEAR;
      endcase
   end

   always_comb begin
      run      = (state == ST_RUN);
      drw.busy = ~run;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (run) cnt <= '0;
      else          cnt <= cnt + 1'b1;
   end

   assign hb_edge = HB & ~hb_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hb_r         <= 1'b0;
         line_r       <= 1'b0;
         line_start_r <= 1'b0;
      end else begin
         hb_r         <= HB;
         line_start_r <= run & hb_edge;
         if (run && hb_edge) line_r <= ~line_r;
      end
   end

   assign drw.line       = line_r;
   assign drw.line_start = line_start_r;

   // Display read side: remember which half was read and queue its erase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_r        <= 1'b1;
         blank_r      <= 1'b1;
         erase_pend_r <= 1'b0;
         erase_addr_r <= '0;
      end else if (!run) begin
         blank_r      <= 1'b1;
         erase_pend_r <= 1'b0;
      end else if (pxl_cen) begin
         sel_r        <= ~line_r;
         blank_r      <= HB;
         erase_addr_r <= hdump;
         erase_pend_r <= ~HB;
      end else begin
         erase_pend_r <= 1'b0;
      end
   end

   assign obj_pxl = blank_r ? TRANSP_PXL : rdata[sel_r];

`ifdef JTCPS1_OBJ_FIRSTWIN_EN
   logic          wr_pend_r, wr_half_r;
   logic [AW-1:0] wr_addr_r;
   logic [DW-1:0] wr_data_r;

   // First clk of a write samples the target; the second commits only over transparency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_pend_r <= 1'b0;
         wr_half_r <= 1'b0;
         wr_addr_r <= '0;
         wr_data_r <= '0;
      end else begin
         wr_pend_r <= run & drw.buf_wr & ~is_transp(drw.buf_data);
         wr_half_r <= line_r;
         wr_addr_r <= drw.buf_addr;
         wr_data_r <= drw.buf_data;
      end
   end

   assign drw_we   = run & wr_pend_r & is_transp(rdata[wr_half_r]);
   assign drw_half = wr_half_r;
   assign drw_addr = wr_addr_r;
   assign drw_data = wr_data_r;
   assign drw_rd   = run & drw.buf_wr;
`else
   assign drw_we   = run & drw.buf_wr & ~is_transp(drw.buf_data);
   assign drw_half = line_r;
   assign drw_addr = drw.buf_addr;
   assign drw_data = drw.buf_data;
   assign drw_rd   = 1'b0;
`endif

   for (genvar h = 0; h < 2; h++) begin : g_half
      localparam logic HALF = 1'(h);
      logic          we, re;
      logic [AW-1:0] waddr, raddr;
      logic [DW-1:0] wdata;

      // Port steering: clear sweep, drawer write, or erase behind the display read.
      always_comb begin
         we    = 1'b0;
         waddr = cnt[AW-1:0];
         wdata = TRANSP_PXL;
         re    = 1'b0;
         raddr = hdump;
         if (!run) begin
            we = (cnt[AW] == HALF);
         end else if (drw_we && drw_half == HALF) begin
            we    = 1'b1;
            waddr = drw_addr;
            wdata = drw_data;
         end else if (erase_pend_r && line_r != HALF) begin
            we    = 1'b1;
            waddr = erase_addr_r;
         end else begin
            we = 1'b0;
         end
         if (run && line_r != HALF) begin
            re    = pxl_cen;
            raddr = hdump;
         end else if (run && drw_rd) begin
            re    = 1'b1;
            raddr = drw.buf_addr;
         end else begin
            re = 1'b0;
         end
      end

      jtcps1_linebuf_half #(.AW(AW), .DW(DW)) u_half (
         .clk   (clk),
         .we    (we),
         .waddr (waddr),
         .wdata (wdata),
         .re    (re),
         .raddr (raddr),
         .rdata (rdata[h])
      );
   end
endmodule

// File: tb/tb_jtcps1_obj_linebuf.sv
// Directed self-checking bench for jtcps1_obj_linebuf.
module tb_jtcps1_obj_linebuf;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pxl_cen = 1'b0;
   logic       HB = 1'b0;
   logic [8:0] hdump = 9'd0;
   logic [8:0] obj_pxl;
   int         n_chk = 0;
   int         n_fail = 0;
   logic       exp_line = 1'b0;

   jtcps1_obj_linebuf_if #(.AW(9), .DW(9)) drw ();

   jtcps1_obj_linebuf dut (
      .clk     (clk),
      .rst     (rst),
      .pxl_cen (pxl_cen),
      .HB      (HB),
      .hdump   (hdump),
      .drw     (drw),
      .obj_pxl (obj_pxl)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int x, input logic [8:0] exp, input string tag);
      @(negedge clk);
      hdump   = x[8:0];
      pxl_cen = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("%s x=%0d", tag, x), {23'd0, obj_pxl}, {23'd0, exp});
      @(negedge clk);
      pxl_cen = 1'b0;
   endtask

   task automatic wr(input int a, input logic [8:0] d);
      @(negedge clk);
      drw.buf_addr = a[8:0];
      drw.buf_data = d;
      drw.buf_wr   = 1'b1;
      @(negedge clk);
      drw.buf_wr   = 1'b0;
      @(negedge clk);
   endtask

   task automatic swap(input string tag);
      @(negedge clk);
      HB = 1'b1;
      @(posedge clk);
      #1;
      exp_line = ~exp_line;
      check({tag, " line"}, {31'd0, drw.line}, {31'd0, exp_line});
      check({tag, " line_start hi"}, {31'd0, drw.line_start}, 32'd1);
      @(posedge clk);
      #1;
      check({tag, " line_start lo"}, {31'd0, drw.line_start}, 32'd0);
      @(negedge clk);
      HB = 1'b0;
   endtask

   task automatic wait_clear(input string tag);
      int n;
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (!drw.busy) break;
      end
      check({tag, " busy clks"}, n, 32'd1024);
   endtask

   initial begin
      logic [8:0] e;
      logic [8:0] win30;
      drw.buf_addr = 9'd0;
      drw.buf_data = 9'd0;
      drw.buf_wr   = 1'b0;
`ifdef JTCPS1_OBJ_FIRSTWIN_EN
      win30 = 9'h051;
`else
      win30 = 9'h062;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", {31'd0, drw.busy}, 32'd1);
      check("rst line", {31'd0, drw.line}, 32'd0);
      check("rst line_start", {31'd0, drw.line_start}, 32'd0);
      check("rst obj_pxl", {23'd0, obj_pxl}, 32'h1FF);
      @(negedge clk);
      rst = 1'b0;
      wait_clear("clear1");
      check("after clear obj_pxl", {23'd0, obj_pxl}, 32'h1FF);

      // Both halves transparent after the clear sweep.
      for (int x = 0; x < 512; x++) rd(x, 9'h1FF, "clr half1");
      swap("sw1");
      for (int x = 0; x < 512; x++) rd(x, 9'h1FF, "clr half0");
      swap("sw2");

      wr(10, 9'h123);
      wr(20, 9'h0AF);
      wr(30, 9'h051);
      wr(30, 9'h062);
      swap("sw3");
      for (int x = 0; x < 512; x++) begin
         e = (x == 10) ? 9'h123 : (x == 30) ? win30 : 9'h1FF;
         rd(x, e, "pass1");
      end
      swap("sw4");
      swap("sw5");
      rd(10, 9'h1FF, "erased");
      rd(30, 9'h1FF, "erased");
      rd(20, 9'h1FF, "transp drop");

      // Write coinciding with the HB rising edge lands in the pre-swap half.
      @(negedge clk);
      HB           = 1'b1;
      drw.buf_addr = 9'd40;
      drw.buf_data = 9'h0A5;
      drw.buf_wr   = 1'b1;
      @(posedge clk);
      #1;
      exp_line = ~exp_line;
      check("edge wr line", {31'd0, drw.line}, {31'd0, exp_line});
      @(negedge clk);
      drw.buf_wr = 1'b0;
      @(posedge clk);
      #1;
      check("edge wr line_start lo", {31'd0, drw.line_start}, 32'd0);
      @(negedge clk);
      HB = 1'b0;
      rd(40, 9'h0A5, "edge wr");
      rd(41, 9'h1FF, "edge wr nbr");

      // Reset mid-line: the pending drawn pixel must be wiped.
      wr(50, 9'h033);
      rd(5, 9'h1FF, "midline");
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst busy", {31'd0, drw.busy}, 32'd1);
      check("midrst line", {31'd0, drw.line}, 32'd0);
      check("midrst obj_pxl", {23'd0, obj_pxl}, 32'h1FF);
      @(negedge clk);
      rst = 1'b0;
      exp_line = 1'b0;
      wait_clear("clear2");
      swap("sw6");
      rd(50, 9'h1FF, "post rst");
      rd(10, 9'h1FF, "post rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
